addtree_seq: RTL and testbench

Time-multiplexed four-operand 64-bit adder controller. One registered adder is shared across three sequenced additions, (a+b), (c+d), then the sum of those two, so that a four-input sum costs one adder instead of a three-adder tree. Operands enter through a valid/ready input handshake and the result leaves through a valid/ready output handshake, so the block can sit between pipeline stages that apply backpressure.

---
 rtl/addtree_seq_if.sv | 15 +
 rtl/addtree_seq.sv | 40 ++++
 tb/tb_addtree_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/addtree_seq_if.sv
// addtree_seq_if: operand/result handshake bundle for addtree_seq
interface addtree_seq_if #(parameter int W = 64);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic         busy;
  modport master (output in_valid, a, b, c, d, out_ready, input in_ready, out_valid, q, busy);
  modport slave  (input in_valid, a, b, c, d, out_ready, output in_ready, out_valid, q, busy);
endinterface

// File: rtl/addtree_seq.sv
// addtree_seq: four-operand sum sequenced through one shared registered adder
module addtree_seq #(parameter int W = 64) (
  input logic clk,
  input logic reset,
  addtree_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADD_AB, ADD_CD, ADD_SUM, DONE} state_t;
  state_t state, nxt;
  logic [W-1:0] ra, rb, rc, rd, t1, t2, rq, opa, opb, sum;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.in_valid ? ADD_AB : IDLE;
      ADD_AB:  nxt = ADD_CD;
      ADD_CD:  nxt = ADD_SUM;
      ADD_SUM: nxt = DONE;
      DONE:    nxt = bus.out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  assign opa = state == ADD_AB ? ra : state == ADD_CD ? rc : t1;
  assign opb = state == ADD_AB ? rb : state == ADD_CD ? rd : t2;
  assign sum = opa + opb;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {ra, rb, rc, rd} <= '0;
      {t1, t2, rq} <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.in_valid) {ra, rb, rc, rd} <= {bus.a, bus.b, bus.c, bus.d};
      if (state == ADD_AB) t1 <= sum;
      if (state == ADD_CD) t2 <= sum;
      if (state == ADD_SUM) rq <= sum;
    end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.q         = rq;
endmodule

// File: tb/tb_addtree_seq.sv
// tb_addtree_seq: vector table, random model and handshake corner sequences
module tb_addtree_seq;
  typedef logic [63:0] w_t;
  typedef struct {w_t a; w_t b; w_t c; w_t d; w_t exp;} vec_t;
  logic clk = 0;
  logic reset = 0;
  int vec = 0;
  int err = 0;
  addtree_seq_if #(.W(64)) bus();
  addtree_seq #(.W(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input w_t got, input w_t exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input w_t a, input w_t b, input w_t c, input w_t d, output int lat, output w_t q, output logic bsy);
    int k = 0;
    while (!bus.in_ready && k < 20) begin
      step();
      k++;
    end
    {bus.a, bus.b, bus.c, bus.d} = {a, b, c, d};
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    lat = 0;
    bsy = bus.busy;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
      bsy &= bus.busy;
    end
    q = bus.q;
  endtask
  task automatic drain(input string nm);
    bus.out_ready = 1;
    step();
    chk({nm, "_in_ready"}, w_t'(bus.in_ready), 1);
    chk({nm, "_out_valid"}, w_t'(bus.out_valid), 0);
  endtask
  initial begin
    vec_t tbl[6];
    int lat;
    w_t q;
    logic bsy;
    tbl[0] = '{1, 2, 3, 4, 10};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[2] = '{0, 0, 0, 0, 0};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5, 7, 12};
    tbl[4] = '{64'h1234, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h1234};
    tbl[5] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 0, 64'h0000_0000_0000_0001, 64'h1234_5678_9ABC_DF01};
    bus.in_valid = 1;
    bus.out_ready = 0;
    {bus.a, bus.b, bus.c, bus.d} = {64'd7, 64'd7, 64'd7, 64'd7};
    repeat (3) step();
    chk("rst_in_ready", w_t'(bus.in_ready), 1);
    chk("rst_out_valid", w_t'(bus.out_valid), 0);
    chk("rst_busy", w_t'(bus.busy), 0);
    chk("rst_q", bus.q, 0);
    bus.in_valid = 0;
    reset = 1;
    step();
    chk("rel_in_ready", w_t'(bus.in_ready), 1);
    chk("rel_busy", w_t'(bus.busy), 0);
    bus.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, lat, q, bsy);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].exp);
      chk($sformatf("tbl%0d_lat", i), w_t'(lat), 3);
      chk($sformatf("tbl%0d_busy", i), w_t'(bsy), 1);
      drain($sformatf("tbl%0d", i));
    end
    bus.out_ready = 0;
    send(64'h10, 64'h20, 64'h30, 64'h40, lat, q, bsy);
    chk("bp_lat", w_t'(lat), 3);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d_q", i), bus.q, 64'hA0);
      chk($sformatf("bp%0d_valid", i), w_t'(bus.out_valid), 1);
      chk($sformatf("bp%0d_in_ready", i), w_t'(bus.in_ready), 0);
      chk($sformatf("bp%0d_busy", i), w_t'(bus.busy), 1);
      step();
    end
    drain("bp");
    begin
      int acc[$];
      w_t expq[2] = '{4, 26};
      int cyc = 0;
      int got = 0;
      int diff;
      logic will_acc;
      {bus.a, bus.b, bus.c, bus.d} = {64'd1, 64'd1, 64'd1, 64'd1};
      bus.in_valid = 1;
      bus.out_ready = 1;
      while (got < 2 && cyc < 40) begin
        will_acc = bus.in_ready && bus.in_valid;
        if (bus.out_valid) begin
          chk($sformatf("b2b%0d_q", got), bus.q, expq[got]);
          got++;
        end
        step();
        cyc++;
        if (will_acc) begin
          acc.push_back(cyc);
          {bus.a, bus.b, bus.c, bus.d} = {64'd5, 64'd6, 64'd7, 64'd8};
        end
      end
      bus.in_valid = 0;
      diff = acc.size() >= 2 ? acc[1] - acc[0] : -1;
      chk("b2b_results", w_t'(got), 2);
      chk("b2b_interval", w_t'(diff), 5);
      chk("b2b_idle", w_t'(bus.in_ready), 1);
    end
    for (int i = 0; i < 20; i++) begin
      w_t ra = {$urandom, $urandom}, rb = {$urandom, $urandom};
      w_t rc = {$urandom, $urandom}, rd = {$urandom, $urandom};
      bus.out_ready = 1;
      send(ra, rb, rc, rd, lat, q, bsy);
      chk($sformatf("rnd%0d_q", i), q, ra + rb + rc + rd);
      chk($sformatf("rnd%0d_lat", i), w_t'(lat), 3);
      step();
    end
    {bus.a, bus.b, bus.c, bus.d} = {64'd9, 64'd9, 64'd9, 64'd9};
    bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    step();
    #2;
    reset = 0;
    #1;
    chk("mid_in_ready", w_t'(bus.in_ready), 1);
    chk("mid_out_valid", w_t'(bus.out_valid), 0);
    chk("mid_busy", w_t'(bus.busy), 0);
    chk("mid_q", bus.q, 0);
    step();
    reset = 1;
    begin
      logic seen = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        seen |= bus.out_valid;
      end
      chk("mid_no_result", w_t'(seen), 0);
    end
    send(1, 0, 0, 0, lat, q, bsy);
    chk("mid_new_q", q, 1);
    chk("mid_new_lat", w_t'(lat), 3);
    drain("mid_new");
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
